// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] HALT_WORD        = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;

  function automatic logic is_halt_word(input logic [31:0] word);
    return (word == HALT_WORD);
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Synchronous FIFO of {pc, data} entries; flush clears occupancy, storage is never reset.
module inst_queue #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  // Pointer and occupancy next-state; flush overrides any push or pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_i) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Sequential word-addressed instruction fetch with redirect, halt detection and a decode queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        halted
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          halted_q, halted_d;
  logic          issue_s;
  logic          pop_s;
  logic [CW-1:0] q_count_s;
  logic [63:0]   q_head_s;
  logic          inst_valid_s;

  assign inst_valid_s = (q_count_s != '0);

  // State register plus the registers that follow it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      halted_q   <= halted_d;
    end
  end

  // Next-state logic; a redirect re-enters IDLE/FETCH from anywhere, including HALT.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = en ? ST_FETCH : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) state_d = ST_FETCH;
          else    state_d = ST_IDLE;
        end
        ST_FETCH: begin
          if (!en)                                        state_d = ST_IDLE;
          else if (issue_s && is_halt_word(mem_rdata))    state_d = ST_HALT;
          else                                            state_d = ST_FETCH;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: a full queue can still accept a fetch when its head leaves this cycle.
  always_comb begin
    pop_s   = 1'b0;
    issue_s = 1'b0;
    pop_s   = inst_valid_s && inst_ready && !redirect_valid;
    if ((state_q == ST_FETCH) && en && !redirect_valid) begin
      issue_s = (q_count_s < QDEPTH_C) || pop_s;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Fetch address and halt flag next values.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue_s) begin
      fetch_pc_d = fetch_pc_q + 32'd1;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
    halted_d = (state_d == ST_HALT);
  end

  inst_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (issue_s),
    .pop_i   (pop_s),
    .wdata_i ({fetch_pc_q, mem_rdata}),
    .rdata_o (q_head_s),
    .count_o (q_count_s)
  );

  assign mem_raddr  = fetch_pc_q;
  assign inst_valid = inst_valid_s;
  assign inst_pc    = q_head_s[63:32];
  assign inst_data  = q_head_s[31:0];
  assign halted     = halted_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: word address of the first fetch after reset.
REQ-002 SHALL have parameter QDEPTH, default 4: instruction queue depth; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port en  input  1  fetch enable.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  32  redirect target word address.
REQ-008 SHALL have port mem_raddr  output  32  read address to the instruction memory.
REQ-009 SHALL have port mem_rdata  input  32  read data from the instruction memory.
REQ-010 SHALL have port inst_valid  output  1  queue head holds a valid instruction.
REQ-011 SHALL have port inst_data  output  32  instruction word at the queue head.
REQ-012 SHALL have port inst_pc  output  32  word address of inst_data.
REQ-013 SHALL have port inst_ready  input  1  decode accepts the head this cycle.
REQ-014 SHALL have port halted  output  1  a halt word has been fetched and fetching has stopped.

Function
REQ-015 SHALL use word addressing: sequential fetch increments fetch_pc by 1, modulo 2^32.
REQ-016 SHALL drive mem_raddr directly from the registered fetch_pc, so it changes only after a rising edge.
REQ-017 SHALL treat memory read latency as same-cycle: memory reads on the falling edge, and mem_rdata is sampled on the rising edge that ends the cycle in which mem_raddr was presented.
REQ-018 SHALL have FSM states IDLE, FETCH and HALT.
REQ-019 SHALL transition IDLE->FETCH when en=1, and FETCH->IDLE when en=0; no fetch is issued in the cycle en=0.
REQ-020 SHALL issue a fetch in FETCH when (count<QDEPTH) or (inst_valid and inst_ready); the issue pushes {fetch_pc, mem_rdata} to the queue and advances fetch_pc.
REQ-021 SHALL hold fetch_pc and push nothing when the queue is full and not popping.
REQ-022 SHALL pop the head on inst_valid and inst_ready, in all states.
REQ-023 SHALL permit push and pop in the same cycle; count is then unchanged, including when full.
REQ-024 SHALL drive inst_valid = (count!=0); inst_data and inst_pc reflect the head entry, and their value is don't-care when inst_valid=0.
REQ-025 SHALL wrap queue read and write pointers modulo QDEPTH.
REQ-026 SHALL, when a pushed word equals HALT_WORD (32'hFFFFFFFF), push it, enter HALT, set halted=1 and stop issuing fetches; the queue still drains in HALT.
REQ-027 SHALL, on redirect_valid=1 in any state: flush the queue (count=0), discard that cycle's fetch and pop, set fetch_pc=redirect_pc, clear halted, and go to FETCH if en=1, else IDLE.
REQ-028 SHALL apply priority rst > redirect_valid > normal operation.

Reset
REQ-029 SHALL, when rst=1 at a rising edge, set state=IDLE, fetch_pc=mem_raddr=RESET_PC, count=0, pointers=0, inst_valid=0 and halted=0, aborting any operation in progress.
REQ-030 SHALL leave queue storage contents uninitialised on reset; only the control state is reset.

Structure
REQ-031 SHALL place the FSM state enum, HALT_WORD and the RESET_PC default in shared package fetch_pkg.
REQ-032 SHALL implement the queue as sub-module inst_queue, a synchronous FIFO with push, pop, count, and 64-bit {pc, data} entries.

Verification
REQ-033 SHALL cover straight-line fetch: memory words 0..7 = 100..107, en=1, inst_ready=1 -> inst_pc 0,1,2,... with inst_data 100,101,... one per cycle after the first.
REQ-034 SHALL cover backpressure: inst_ready=0 for 10 cycles -> count reaches 4, mem_raddr holds at 4; then ready=1 -> PCs 0..7 in order with no gaps.
REQ-035 SHALL cover redirect with a full queue: redirect_pc=40 -> next cycle inst_valid=0, then mem_raddr=40 and the first inst_pc=40.
REQ-036 SHALL cover halt: word 3 = 32'hFFFFFFFF -> halted=1, PCs 0..3 delivered, mem_raddr stays 4; a later redirect to 0 clears halted and resumes fetch.
REQ-037 SHALL cover reset mid-run: rst pulse while the queue is non-empty -> inst_valid=0, mem_raddr=RESET_PC and state IDLE on the next cycle.
REQ-038 SHALL cover simultaneous push and pop at full: count stays 4 and order is preserved across pointer wrap (PCs 0..11).
